// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and request classification for the data-memory responder
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef enum logic [1:0] {ERR_NONE, ERR_ALIGN, ERR_RANGE, ERR_RDWR} err_t;

  // A simultaneous rd/wr outranks address faults: neither operation is meaningful.
  function automatic err_t classify(input logic [31:0] addr, input logic rd,
                                    input logic wr, input logic [31:0] nwords);
    if (rd && wr)                       return ERR_RDWR;
    else if (addr[1:0] != 2'b00)        return ERR_ALIGN;
    else if ({2'b00, addr[31:2]} >= nwords) return ERR_RANGE;
    else                                return ERR_NONE;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous word RAM with registered read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int NWORDS = 256,
  parameter int AW     = $clog2(NWORDS)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  // Contents start at zero and are never cleared by reset.
  logic [WORD_W-1:0] r_mem [NWORDS] = '{default: '0};
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle MEM-stage load/store responder with stall and error flags
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int NWORDS  = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        stall,
  output logic        err
);

  localparam int AW = $clog2(NWORDS);

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic          r_rd;
  logic          r_wr;
  err_t          r_cause;
  logic          r_zero;

  err_t          w_cause;
  err_t          w_cur_cause;
  logic          w_accept;
  logic          w_enter_resp;
  logic          w_cur_load;
  logic          w_load_ok;
  logic          w_load_bad;
  logic          w_we;
  logic [AW-1:0] w_mem_addr;
  logic [31:0]   w_ram_rdata;

  assign w_cause      = classify(addr, rd, wr, 32'(NWORDS));
  assign w_accept     = (r_state == IDLE) && (rd || wr);
  assign w_enter_resp = (w_accept && (LATENCY == 1)) || ((r_state == WAIT) && (r_cnt == 4'd0));

  // With LATENCY=1 the read is issued on the accepting edge, before the capture registers hold it.
  assign w_cur_load  = (r_state == IDLE) ? (rd && !wr) : (r_rd && !r_wr);
  assign w_cur_cause = (r_state == IDLE) ? w_cause : r_cause;
  assign w_mem_addr  = (r_state == IDLE) ? addr[AW+1:2] : r_idx;

  assign w_load_ok  = w_enter_resp && w_cur_load && (w_cur_cause == ERR_NONE) && !rst;
  assign w_load_bad = w_enter_resp && w_cur_load && (w_cur_cause != ERR_NONE);
  assign w_we       = (r_state == RESP) && r_wr && !r_rd && (r_cause == ERR_NONE) && !rst;

  dmem_array #(.NWORDS(NWORDS)) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_load_ok),
    .i_addr  (w_mem_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_cause <= ERR_NONE;
      r_zero  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (rd || wr) begin
          r_idx   <= addr[AW+1:2];
          r_wdata <= wdata;
          r_rd    <= rd;
          r_wr    <= wr;
          r_cause <= w_cause;
          if (LATENCY == 1) begin
            r_state <= RESP;
          end else begin
            r_state <= WAIT;
            r_cnt   <= 4'(LATENCY - 2);
          end
        end
        WAIT: if (r_cnt == 4'd0) r_state <= RESP;
              else r_cnt <= r_cnt - 4'd1;
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      // rdata shows zero after a faulted load until the next good load lands.
      if (w_load_ok)       r_zero <= 1'b0;
      else if (w_load_bad) r_zero <= 1'b1;
    end
  end

  assign ack   = (r_state == RESP);
  assign err   = ack && (r_cause != ERR_NONE);
  assign stall = (rd || wr) && !ack;
  assign rdata = r_zero ? '0 : w_ram_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench driving LATENCY=1,2,3 responders
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_i    [3];
  logic        wr_i    [3];
  logic [31:0] addr_i  [3];
  logic [31:0] wdata_i [3];
  logic [31:0] rdata_o [3];
  logic        ack_o   [3];
  logic        stall_o [3];
  logic        err_o   [3];

  logic [31:0] mdl [3][256];
  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.NWORDS(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .addr(addr_i[0]), .rd(rd_i[0]), .wr(wr_i[0]), .wdata(wdata_i[0]),
    .rdata(rdata_o[0]), .ack(ack_o[0]), .stall(stall_o[0]), .err(err_o[0]));
  dmem_responder #(.NWORDS(256), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .addr(addr_i[1]), .rd(rd_i[1]), .wr(wr_i[1]), .wdata(wdata_i[1]),
    .rdata(rdata_o[1]), .ack(ack_o[1]), .stall(stall_o[1]), .err(err_o[1]));
  dmem_responder #(.NWORDS(256), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .addr(addr_i[2]), .rd(rd_i[2]), .wr(wr_i[2]), .wdata(wdata_i[2]),
    .rdata(rdata_o[2]), .ack(ack_o[2]), .stall(stall_o[2]), .err(err_o[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Index k selects the instance whose LATENCY is k+1.
  task automatic access(input int k, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit drop);
    exp_t e;
    exp_t got;
    int   cyc;
    bit   legal;
    bit   timed_out;
    legal    = (a[1:0] == 2'b00) && (a[31:2] < 30'd256) && !(r && w);
    e.err    = !legal;
    e.chk_rd = r && !w;
    e.rdata  = (r && !w && legal) ? mdl[k][a[9:2]] : 32'h0;
    e.lat    = k + 1;
    if (w && !r && legal) mdl[k][a[9:2]] = d;
    sb.push_back(e);
    rd_i[k] = r; wr_i[k] = w; addr_i[k] = a; wdata_i[k] = d;
    cyc = 0;
    timed_out = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_o[k]) break;
      if (!drop || cyc == 0) chk("stall_wait", 32'(stall_o[k]), 32'd1);
      if (cyc > 30) begin
        n_tests++;
        n_fail++;
        $error("FAIL ack_timeout: observed no ack after %0d cycles expected ack", cyc);
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (drop && cyc == 1) begin
        rd_i[k] = 1'b0; wr_i[k] = 1'b0;
      end
    end
    got = sb.pop_front();
    if (!timed_out) begin
      chk("latency", 32'(cyc), 32'(got.lat));
      chk("err", 32'(err_o[k]), 32'(got.err));
      chk("stall_resp", 32'(stall_o[k]), 32'd0);
      if (got.chk_rd) chk("rdata", rdata_o[k], got.rdata);
    end
    @(posedge clk); #1;
    rd_i[k] = 1'b0; wr_i[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rd_i[k] = 1'b0; wr_i[k] = 1'b0; addr_i[k] = 32'h0; wdata_i[k] = 32'h0;
      for (int j = 0; j < 256; j++) mdl[k][j] = 32'h0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_ack", 32'(ack_o[k]), 32'd0);
      chk("reset_err", 32'(err_o[k]), 32'd0);
      chk("reset_rdata", rdata_o[k], 32'h0);
      chk("reset_stall", 32'(stall_o[k]), 32'd0);
    end
    @(posedge clk); #1;

    // LATENCY=2: store/load, faulted loads, protocol error
    access(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    access(1, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
    access(1, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    access(1, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0);
    access(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    access(1, 1'b0, 1'b1, 32'd1024, 32'h55AA55AA, 1'b0);

    // LATENCY=1: back-to-back alternating store/load on words 0 and 1
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) access(0, 1'b0, 1'b1, 32'(((i / 2) % 2) * 4), $urandom, 1'b0);
      else            access(0, 1'b1, 1'b0, 32'(((i / 2) % 2) * 4), 32'h0, 1'b0);
    end

    // LATENCY=3: request withdrawn during WAIT still completes
    access(2, 1'b0, 1'b1, 32'h40, 32'hA5A5_0F0F, 1'b0);
    access(2, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);

    // LATENCY=3: reset in WAIT discards a pending store
    rd_i[2] = 1'b0; wr_i[2] = 1'b1; addr_i[2] = 32'h8; wdata_i[2] = 32'hCAFEF00D;
    @(negedge clk);
    chk("rst_stall", 32'(stall_o[2]), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_ack", 32'(ack_o[2]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; wr_i[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_ack", 32'(ack_o[2]), 32'd0);
      chk("rst_no_err", 32'(err_o[2]), 32'd0);
    end
    @(posedge clk); #1;
    access(2, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
    access(2, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the 5-stage pipeline's MEM stage; it is the target end of the CPU's load/store interface (addr, rd, wr, wdata, rdata).
- It replaces the zero-wait data memory with a multi-cycle responder. The latency in cycles is configurable.
- It raises a stall to hold the pipeline until each access completes, and flags misaligned, out-of-range or illegal requests.

Parameters:
- NWORDS, 256, number of 32-bit words in storage; must be a power of two.
- LATENCY, 2, cycles from request acceptance to ack; minimum 1, maximum 15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  32  byte address from the MEM stage (ALU result).
- rd  input  1  load request.
- wr  input  1  store request.
- wdata  input  32  store data.
- rdata  output  32  load data; valid while ack=1 and held until the next ack.
- ack  output  1  one-cycle pulse: the access has completed.
- stall  output  1  combinational; high while a request is presented and ack=0.
- err  output  1  one-cycle pulse, coincident with ack, on an erroneous request.

Behaviour:
- Reset values: state=IDLE, ack=0, err=0, rdata=0, wait counter=0. Memory contents are not cleared by rst; all words are zero at time 0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If rd|wr is high, capture addr, wdata and the rd/wr kind.
  - Go to RESP when LATENCY=1; otherwise go to WAIT with counter=LATENCY-2.
- WAIT: decrement the counter each cycle; go to RESP when the counter is 0 at a clock edge.
- RESP:
  - ack=1 for exactly this one cycle.
  - Return to IDLE. The next request can be accepted on the following cycle.
- Latency and throughput:
  - Acceptance at cycle T gives ack at cycle T+LATENCY.
  - Back-to-back accesses complete one per LATENCY+1 cycles.
- Stall output:
  - stall = (rd|wr) & ~ack.
  - The CPU holds addr, rd, wr and wdata stable while stall=1. The responder uses the captured copies.
- Store: memory word addr[log2(NWORDS)+1:2] is written with the captured wdata on the clock edge ending the RESP cycle. rdata is unchanged.
- Load: rdata is loaded from the memory word on entry to RESP and held until the next load ack.
- Error cases (err=1 with ack; no memory access; rdata is forced to 0 on a load error):
  - misaligned address, addr[1:0]!=0;
  - out of range, addr[31:2] >= NWORDS;
  - rd and wr both high at acceptance. This is treated as a protocol error and neither operation is performed.
- The error check is made at acceptance and latched. The latency is the same as for a good access.
- Request removed early: if rd|wr falls while in WAIT, the captured access still completes. Changes to the inputs after acceptance are ignored.
- rst asserted in WAIT or RESP:
  - The pending access is discarded; a pending write never reaches memory.
  - ack and err go to 0 on the next edge, and the state returns to IDLE.
- Wrap-around: none. Addresses at or beyond NWORDS*4 are errors; they are not aliased.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, WAIT, RESP};
  - word-width constant 32;
  - error-cause encoding {ERR_NONE, ERR_ALIGN, ERR_RANGE, ERR_RDWR}, kept internally for debug visibility.
- Sub-module dmem_array: single-port synchronous RAM (NWORDS x 32, write enable, registered read), instantiated once. The FSM, counter and error logic stay in dmem_responder.

Test Plan:
- LATENCY=2, after rst: store wr=1, addr=0x10, wdata=0xDEADBEEF at cycle T.
  - stall=1 for T, T+1; ack=1, err=0 at T+2.
  - Then load rd=1 addr=0x10: rdata=0xDEADBEEF with ack three cycles later.
- LATENCY=1: alternating load/store to 0x0 and 0x4.
  - ack every 2nd cycle; stall never high in a RESP cycle; read data matches the prior writes.
- Misaligned load addr=0x13 and out-of-range addr=NWORDS*4:
  - err=ack=1 at T+LATENCY; rdata=0.
  - A stored word at 0x10 is unchanged on readback.
- rd=wr=1, addr=0x20, wdata=0x12345678:
  - err=1 with ack.
  - A later load of 0x20 returns the prior value 0x0.
- rst pulse in WAIT of store wr=1, addr=0x8, wdata=0xCAFEF00D (LATENCY=3):
  - No ack; state returns to IDLE.
  - A load of 0x8 returns 0x0.
- Request dropped during WAIT (rd falls at T+1, LATENCY=3): ack still at T+3 with the correct data.
